// File: rtl/upcounter_mod.sv
// ---------------------------------------------------------------------------
// upcounter_mod
//   Programmable up-counter with a runtime terminal value. At the terminal
//   count it either wraps to zero (sat_mode = 0) or parks in a saturated
//   state (sat_mode = 1). It provides a terminal-count decode, a one-cycle
//   wrap pulse and a sticky overflow flag.
//
// Ports
//   clk       in   rising-edge clock
//   rest      in   synchronous active-high reset (highest priority)
//   en        in   count enable
//   load      in   synchronous parallel load (overrides en)
//   load_val  in   value to load, clamped to max_val
//   max_val   in   terminal count value, may change at any time
//   sat_mode  in   0 = wrap at terminal, 1 = saturate at terminal
//   clr_ovf   in   clears the sticky overflow flag
//   cnt       out  registered count
//   tc        out  combinational cnt == max_val
//   wrap      out  registered pulse, high the cycle after cnt wrapped to 0
//   ovf       out  registered sticky flag, set on every terminal event
//   sat       out  registered, high while the FSM is in SAT; this also
//                  exposes the FSM state
// ---------------------------------------------------------------------------
module upcounter_mod #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             sat_mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             sat
);

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_SAT   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q <= ST_COUNT;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        // clr_ovf clears by default. A terminal event below sets the flag
        // again, so on a simultaneous edge the event wins.
        ovf_d   = ovf_q & ~clr_ovf;

        if (load) begin
            cnt_d   = (load_val <= max_val) ? load_val : max_val;
            state_d = ST_COUNT;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (en) begin
                        if (cnt_q < max_val) begin
                            cnt_d = cnt_q + 1'b1;
                        end else if (!sat_mode) begin
                            // Terminal event. The >= compare also covers
                            // cnt above a max_val that was lowered at runtime.
                            cnt_d  = '0;
                            wrap_d = 1'b1;
                            ovf_d  = 1'b1;
                        end else begin
                            cnt_d   = max_val;
                            state_d = ST_SAT;
                            ovf_d   = 1'b1;
                        end
                    end
                end
                ST_SAT: begin
                    // The count is frozen. Dropping sat_mode only returns to
                    // COUNT, so the wrap happens on a later enabled edge.
                    if (!sat_mode) begin
                        state_d = ST_COUNT;
                    end
                end
                default: begin
                    state_d = ST_COUNT;
                end
            endcase
        end
    end

    assign cnt  = cnt_q;
    assign tc   = (cnt_q == max_val);
    assign wrap = wrap_q;
    assign ovf  = ovf_q;
    assign sat  = (state_q == ST_SAT);

endmodule

// File: tb/tb_upcounter_mod.sv
// ---------------------------------------------------------------------------
// tb_upcounter_mod
//   Directed bench for upcounter_mod. Each scenario task drives its inputs
//   and compares the outputs against hand-computed values. Inputs change
//   and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_upcounter_mod;

    localparam int W = 4;

    logic         clk;
    logic         rest;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] max_val;
    logic         sat_mode;
    logic         clr_ovf;
    logic [W-1:0] cnt;
    logic         tc;
    logic         wrap;
    logic         ovf;
    logic         sat;

    int errors = 0;
    int checks = 0;

    upcounter_mod #(.WIDTH(W)) dut (
        .clk      (clk),
        .rest     (rest),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .sat_mode (sat_mode),
        .clr_ovf  (clr_ovf),
        .cnt      (cnt),
        .tc       (tc),
        .wrap     (wrap),
        .ovf      (ovf),
        .sat      (sat)
    );

    // Clock: 20 ns period.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rest = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
        max_val = 4'd15; sat_mode = 1'b0; clr_ovf = 1'b0;
        step();
        rest = 1'b0;
    endtask

    task automatic test_reset();
        rest = 1'b1; en = 1'b1; load = 1'b0; load_val = '0;
        max_val = 4'd15; sat_mode = 1'b0; clr_ovf = 1'b0;
        // Reset is held for 5 cycles (100 ns).
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (cnt !== 4'd0 || wrap !== 1'b0 || ovf !== 1'b0 || sat !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: cnt=%0d wrap=%b ovf=%b sat=%b, required cnt=0 wrap=0 ovf=0 sat=0",
                         cnt, wrap, ovf, sat);
            end
        end
        rest = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            checks++;
            if (cnt !== 4'(i) || tc !== (i == 15) || wrap !== 1'b0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL count_step: cnt=%0d tc=%b wrap=%b ovf=%b, required cnt=%0d tc=%b wrap=0 ovf=0",
                         cnt, tc, wrap, ovf, i, (i == 15));
            end
        end
        step();
        checks++;
        if (cnt !== 4'd0 || tc !== 1'b0 || wrap !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL count_wrap: cnt=%0d tc=%b wrap=%b ovf=%b, required cnt=0 tc=0 wrap=1 ovf=1",
                     cnt, tc, wrap, ovf);
        end
        step();
        checks++;
        if (cnt !== 4'd1 || wrap !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_one_cycle: cnt=%0d wrap=%b ovf=%b, required cnt=1 wrap=0 ovf=1",
                     cnt, wrap, ovf);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        max_val = 4'd9; sat_mode = 1'b1; en = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            checks++;
            if (cnt !== 4'(i) || sat !== 1'b0 || wrap !== 1'b0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL sat_ramp: cnt=%0d sat=%b wrap=%b ovf=%b, required cnt=%0d sat=0 wrap=0 ovf=0",
                         cnt, sat, wrap, ovf, i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (cnt !== 4'd9 || sat !== 1'b1 || ovf !== 1'b1 || wrap !== 1'b0 || tc !== 1'b1) begin
                errors++;
                $display("FAIL sat_hold: cnt=%0d sat=%b ovf=%b wrap=%b tc=%b, required cnt=9 sat=1 ovf=1 wrap=0 tc=1",
                         cnt, sat, ovf, wrap, tc);
            end
        end
        sat_mode = 1'b0;
        step();
        checks++;
        if (cnt !== 4'd9 || sat !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL sat_leave: cnt=%0d sat=%b wrap=%b, required cnt=9 sat=0 wrap=0", cnt, sat, wrap);
        end
        step();
        checks++;
        if (cnt !== 4'd0 || wrap !== 1'b1 || sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_then_wrap: cnt=%0d wrap=%b sat=%b, required cnt=0 wrap=1 sat=0", cnt, wrap, sat);
        end
    endtask

    task automatic test_load();
        do_reset();
        max_val = 4'd15; en = 1'b1;
        step(); step(); step();
        checks++;
        if (cnt !== 4'd3) begin
            errors++;
            $display("FAIL load_setup: cnt=%0d, required 3", cnt);
        end
        load = 1'b1; load_val = 4'd12;
        step();
        checks++;
        if (cnt !== 4'd12 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_over_en: cnt=%0d wrap=%b, required cnt=12 wrap=0", cnt, wrap);
        end
        load_val = 4'd14; max_val = 4'd10;
        step();
        checks++;
        if (cnt !== 4'd10 || tc !== 1'b1) begin
            errors++;
            $display("FAIL load_clamp: cnt=%0d tc=%b, required cnt=10 tc=1", cnt, tc);
        end
        rest = 1'b1;
        step();
        checks++;
        if (cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_over_load: cnt=%0d, required 0", cnt);
        end
        // A load issued while saturated returns the FSM to COUNT.
        rest = 1'b0; load = 1'b0; max_val = 4'd2; sat_mode = 1'b1;
        step(); step(); step();
        load = 1'b1; load_val = 4'd1;
        step();
        checks++;
        if (cnt !== 4'd1 || sat !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL load_from_sat: cnt=%0d sat=%b ovf=%b, required cnt=1 sat=0 ovf=1", cnt, sat, ovf);
        end
        load = 1'b0; sat_mode = 1'b0;
    endtask

    task automatic test_max_drop();
        do_reset();
        max_val = 4'd15; en = 1'b1;
        for (int i = 0; i < 12; i++) step();
        max_val = 4'd5; en = 1'b0;
        step();
        checks++;
        if (cnt !== 4'd12 || tc !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL drop_hold: cnt=%0d tc=%b wrap=%b, required cnt=12 tc=0 wrap=0", cnt, tc, wrap);
        end
        en = 1'b1;
        step();
        checks++;
        if (cnt !== 4'd0 || wrap !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL drop_wrap: cnt=%0d wrap=%b ovf=%b, required cnt=0 wrap=1 ovf=1", cnt, wrap, ovf);
        end
    endtask

    task automatic test_max_zero();
        do_reset();
        max_val = 4'd0; en = 1'b1; sat_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (cnt !== 4'd0 || wrap !== 1'b1 || tc !== 1'b1) begin
                errors++;
                $display("FAIL zero_wrap: cnt=%0d wrap=%b tc=%b, required cnt=0 wrap=1 tc=1", cnt, wrap, tc);
            end
        end
        sat_mode = 1'b1;
        step();
        checks++;
        if (cnt !== 4'd0 || sat !== 1'b1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL zero_sat: cnt=%0d sat=%b wrap=%b, required cnt=0 sat=1 wrap=0", cnt, sat, wrap);
        end
        sat_mode = 1'b0;
    endtask

    task automatic test_ovf();
        // ovf is 1 after the preceding wrap; clear it with the count idle.
        do_reset();
        max_val = 4'd1; en = 1'b1;
        step(); step();
        en = 1'b0; clr_ovf = 1'b1;
        step();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, required 0", ovf);
        end
        clr_ovf = 1'b0;
        do_reset();
        max_val = 4'd15; en = 1'b1;
        for (int i = 0; i < 15; i++) step();
        clr_ovf = 1'b1;
        step();
        checks++;
        if (cnt !== 4'd0 || wrap !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: cnt=%0d wrap=%b ovf=%b, required cnt=0 wrap=1 ovf=1", cnt, wrap, ovf);
        end
        clr_ovf = 1'b0;
        step();
        checks++;
        if (ovf !== 1'b1 || cnt !== 4'd1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b cnt=%0d, required ovf=1 cnt=1", ovf, cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        max_val = 4'd9; sat_mode = 1'b1; en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (cnt !== 4'd9 || sat !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: cnt=%0d sat=%b, required cnt=9 sat=1", cnt, sat);
        end
        rest = 1'b1;
        step();
        checks++;
        if (cnt !== 4'd0 || sat !== 1'b0 || ovf !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: cnt=%0d sat=%b ovf=%b wrap=%b, required all 0", cnt, sat, ovf, wrap);
        end
        rest = 1'b0;
        step();
        checks++;
        if (cnt !== 4'd1 || sat !== 1'b0) begin
            errors++;
            $display("FAIL mid_resume: cnt=%0d sat=%b, required cnt=1 sat=0", cnt, sat);
        end
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_load();
        test_max_drop();
        test_max_zero();
        test_ovf();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/upcounter_mod.md
Name: upcounter_mod

Overview:
- Programmable 4-bit (parameterizable) up-counter; the count-up counterpart of the team's down-counter.
- Counts from 0 toward a runtime terminal value `max_val`.
- Terminal behaviour is selectable: wrap to 0 or saturate.
- Provides a terminal-count decode, a one-cycle wrap pulse and a sticky overflow flag for use by downstream timing and sequencing blocks.

Parameters:
- WIDTH, 4, width of the count, `load_val` and `max_val`.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rest  input  1  synchronous, active-high reset.
- en  input  1  count enable; advance on a rising edge when high.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- max_val  input  WIDTH  terminal count value; may change at any time.
- sat_mode  input  1  0 = wrap at terminal, 1 = saturate at terminal.
- clr_ovf  input  1  clears the sticky overflow flag.
- cnt  output  WIDTH  registered count.
- tc  output  1  high when `cnt == max_val`; combinational compare of registered `cnt` against `max_val`.
- wrap  output  1  registered one-cycle pulse; high the cycle after `cnt` wrapped to 0.
- ovf  output  1  registered sticky flag; set on any terminal event.
- sat  output  1  registered; high while the FSM is in state SAT.

Behaviour:
- One clock, `clk`. Reset `rest` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset values: `cnt` = 0, `wrap` = 0, `ovf` = 0, `sat` = 0, FSM = COUNT.
  - `rest` overrides every other input on that edge, including mid-count or in SAT.
- Edge priority: `rest` > `load` > `en`. With `en` = 0 and `load` = 0, `cnt` holds and `wrap` = 0.
- Load (`load` = 1):
  - `cnt` <= `load_val` if `load_val` <= `max_val`, else `cnt` <= `max_val` (clamp).
  - FSM <= COUNT, `wrap` <= 0, `ovf` is unaffected.
  - `load` overrides `en` on the same edge.
- FSM states: COUNT, SAT.
- COUNT with `en` = 1:
  - `cnt` < `max_val`: `cnt` <= `cnt` + 1.
  - `cnt` >= `max_val` and `sat_mode` = 0 (terminal event): `cnt` <= 0, `wrap` <= 1, `ovf` <= 1.
  - `cnt` >= `max_val` and `sat_mode` = 1 (terminal event): `cnt` <= `max_val`, FSM <= SAT, `ovf` <= 1, `wrap` stays 0.
- SAT:
  - `cnt` holds.
  - `en` = 1 with `sat_mode` = 1: remain in SAT; no further `ovf` set is needed.
  - `sat_mode` sampled 0: FSM <= COUNT with `cnt` unchanged. The next enabled edge then wraps per the COUNT rules.
  - Leaving SAT: only via `rest`, `load`, or `sat_mode` = 0.
- Addition is modulo 2^WIDTH, but `cnt` never exceeds `max_val` through counting.
  - `cnt` > `max_val` can only arise from `max_val` being lowered at runtime; it is treated as terminal on the next enabled edge.
- `max_val` = 0:
  - Wrap mode: `cnt` stays 0 and `wrap` pulses on every enabled edge.
  - Sat mode: enter SAT on the first enabled edge.
- `max_val` = 2^WIDTH-1 (15 at default): full-range count 0..15, then the terminal event.
- `ovf` / `clr_ovf`:
  - `clr_ovf` = 1 clears `ovf` on the next edge.
  - A terminal event on the same edge as `clr_ovf` wins: `ovf` = 1.
- Latency: `cnt`, `wrap`, `ovf` and `sat` reflect an input one edge after sampling. `tc` is valid in the same cycle as `cnt`.

Test Plan:
- Reset and count: `rest` = 1 for 100 ns (20 ns period), then 0, with `en` = 1, `max_val` = 15, `sat_mode` = 0.
  - During reset: `cnt` = 0.
  - After reset: `cnt` steps 0,1,...,15, then 0.
  - `tc` = 1 only while `cnt` = 15; `wrap` = 1 for exactly the one cycle `cnt` = 0; `ovf` = 1 after the wrap.
- Modulus and saturate: `max_val` = 9, `sat_mode` = 1, `en` = 1 from 0.
  - `cnt` reaches 9 and holds; `sat` = 1, `ovf` = 1, `wrap` never asserts.
  - Then set `sat_mode` = 0: next edge leaves SAT, following edge `cnt` = 0 with `wrap` = 1.
- Load and priority: `cnt` = 3, `load` = 1, `load_val` = 12, `en` = 1, `max_val` = 15 gives `cnt` = 12.
  - `load_val` = 14 with `max_val` = 10 gives `cnt` = 10 (clamp).
  - `rest` and `load` together give `cnt` = 0.
- Runtime `max_val` drop: counting with `cnt` = 12, set `max_val` = 5 (wrap mode) -> next enabled edge `cnt` = 0, `wrap` = 1.
  - With `en` = 0 the count holds at 12 and `tc` = 0.
- Sticky flag: after an overflow, `clr_ovf` pulse gives `ovf` = 0.
  - `clr_ovf` asserted on the same edge as a wrap from 15 to 0 leaves `ovf` = 1.
- Reset mid-operation: in SAT with `cnt` = 9, assert `rest` for one cycle -> `cnt` = 0, `sat` = 0, `ovf` = 0, `wrap` = 0 on the next edge.
  - Counting resumes from 0 after `rest` deasserts.
